pingpong_blk_assembler: RTL

Downstream consumer of the 16:1 pipelined sub-block mux. Collects the 8-bit sub-block stream and its per-byte take flag, already aligned by the upstream sequencer to the mux's 4-cycle latency, into 128-bit blocks with a 16-bit take mask. Two ping-pong banks let one block fill while the previous one drains through a valid/ready output port.

---
 rtl/pingpong_pkg.sv | 7 +
 rtl/pingpong_bank.sv | 36 +++
 rtl/pingpong_blk_assembler.sv | 62 ++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared sizing constants for the ping-pong block assembler
package pingpong_pkg;
  localparam int SUBBLK_W   = 8;
  localparam int NUM_SUBBLK = 16;
  localparam int IDX_W      = 4;
  localparam int BLK_W      = SUBBLK_W * NUM_SUBBLK;
endpackage

// File: rtl/pingpong_bank.sv
// pingpong_bank: one block buffer with byte write, take mask and full flag
module pingpong_bank #(
  parameter int SUBBLK_W   = pingpong_pkg::SUBBLK_W,
  parameter int NUM_SUBBLK = pingpong_pkg::NUM_SUBBLK,
  parameter int IDX_W      = pingpong_pkg::IDX_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [SUBBLK_W-1:0]            din,
  input  logic                           set_full,
  input  logic                           clr,
  output logic [SUBBLK_W*NUM_SUBBLK-1:0] data,
  output logic [NUM_SUBBLK-1:0]          mask,
  output logic                           full
);
  // clear on drain, otherwise store taken bytes and mark the block complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      mask <= '0;
      full <= 1'b0;
    end else if (clr) begin
      data <= '0;
      mask <= '0;
      full <= 1'b0;
    end else begin
      if (we) begin
        data[idx*SUBBLK_W +: SUBBLK_W] <= din;
        mask[idx] <= 1'b1;
      end
      if (set_full) full <= 1'b1;
    end
  end
endmodule

// File: rtl/pingpong_blk_assembler.sv
// pingpong_blk_assembler: gathers sub-block beats into blocks across two ping-pong banks
module pingpong_blk_assembler #(
  parameter int SUBBLK_W   = pingpong_pkg::SUBBLK_W,
  parameter int NUM_SUBBLK = pingpong_pkg::NUM_SUBBLK,
  parameter int IDX_W      = pingpong_pkg::IDX_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [IDX_W-1:0]               in_idx,
  input  logic [SUBBLK_W-1:0]            subblki,
  input  logic                           takeblki,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SUBBLK_W*NUM_SUBBLK-1:0] out_data,
  output logic [NUM_SUBBLK-1:0]          out_mask,
  output logic                           overflow,
  output logic [15:0]                    blk_count
);
  logic [SUBBLK_W*NUM_SUBBLK-1:0] bdata [2];
  logic [NUM_SUBBLK-1:0]          bmask [2];
  logic [1:0]                     bfull;
  logic                           wr_bank, rd_bank, acc, rd;
  assign acc       = in_valid & ~bfull[wr_bank];
  assign rd        = bfull[rd_bank] & out_ready;
  assign in_ready  = ~bfull[wr_bank];
  assign out_valid = bfull[rd_bank];
  assign out_data  = bdata[rd_bank];
  assign out_mask  = bmask[rd_bank];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank #(.SUBBLK_W(SUBBLK_W), .NUM_SUBBLK(NUM_SUBBLK), .IDX_W(IDX_W)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .we       (acc & takeblki & (wr_bank == 1'(b))),
      .idx      (in_idx),
      .din      (subblki),
      .set_full (acc & in_last & (wr_bank == 1'(b))),
      .clr      (rd & (rd_bank == 1'(b))),
      .data     (bdata[b]),
      .mask     (bmask[b]),
      .full     (bfull[b])
    );
  end
  // bank pointers advance on block close / drain; overflow latches dropped beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      overflow  <= 1'b0;
      blk_count <= '0;
    end else begin
      if (acc & in_last) begin
        wr_bank   <= ~wr_bank;
        blk_count <= blk_count + 16'd1;
      end
      if (rd) rd_bank <= ~rd_bank;
      if (in_valid & bfull[wr_bank]) overflow <= 1'b1;
    end
  end
endmodule
